debug_entry_ctrl: RTL and testbench
===================================

Name: debug_entry_ctrl

Overview:
- Hart-side debug entry/exit controller; the core-side consumer of the debug module's halt address map and cause codes.
- Detects debug entry events (trigger, ebreak, halt request, single step) and prioritises them.
- Drains the pipeline when needed, writes dpc/dcsr.cause, and redirects fetch to the halt address.
- In debug mode, handles exceptions by redirecting to the exception address; handles dret by resuming at dpc.

Parameters:
- XLEN, 64, PC/dpc width.
- HaltAddr, 64'h800, debug entry vector (HaltAddress).
- ExceptionAddr, 64'h808, debug-mode exception vector (ExceptionAddress).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- debug_req_i  in  1  level halt request from the debug module
- commit_valid_i  in  1  an instruction retires this cycle
- commit_pc_i  in  XLEN  PC of the retiring instruction
- next_pc_i  in  XLEN  architectural next PC after the retiring instruction
- ebreak_i  in  1  retiring instruction is ebreak, already qualified by dcsr.ebreakm/s/u
- trigger_i  in  1  trigger match on the retiring instruction (action = debug)
- step_i  in  1  dcsr.step
- pipe_empty_i  in  1  no instructions in flight
- dret_i  in  1  dret commits (valid only in debug mode)
- dbg_exception_i  in  1  exception raised while in debug mode
- dpc_i  in  XLEN  current dpc CSR value
- halt_o  out  1  stall fetch/issue
- flush_o  out  1  one-cycle pipeline flush
- set_pc_o  out  1  one-cycle PC redirect strobe
- pc_o  out  XLEN  redirect target
- debug_mode_o  out  1  hart is in debug mode
- dpc_we_o  out  1  dpc write strobe
- dpc_o  out  XLEN  dpc write data
- cause_we_o  out  1  dcsr.cause write strobe
- cause_o  out  3  cause code

Behaviour:
- Reset: state RUN; every output 0; internal last_npc, dpc_q and cause_q are 0.
- Reset asserted mid-operation (any state) aborts without any CSR write.
- States: RUN, STEP, DRAIN, ENTER, DEBUG.
- Cause priority: trigger (2) > ebreak (1) > haltreq (3) > step (4).
- Synchronous events (trigger_i/ebreak_i with commit_valid_i):
  - The instruction does not retire architecturally.
  - dpc_q=commit_pc_i, cause_q per priority, go to ENTER next cycle. No drain is needed because flush kills younger instructions.
- last_npc updates to next_pc_i on every commit_valid_i without a sync event.
- RUN:
  - Sync event -> ENTER.
  - Else debug_req_i -> DRAIN with cause_q=3; halt_o=1 from the next cycle.
- STEP (entered on dret with step_i=1):
  - halt_o=0 until the first commit.
  - Sync event on that commit -> ENTER with its cause.
  - Plain commit -> cause_q=4, halt_o=1, DRAIN.
  - debug_req_i before the commit -> DRAIN, cause 3.
- DRAIN:
  - halt_o=1.
  - A sync event committing during drain overrides cause/dpc and goes to ENTER.
  - When pipe_empty_i=1: dpc_q=last_npc (including any commit in the same cycle), then ENTER.
- ENTER (exactly 1 cycle):
  - flush_o=1, set_pc_o=1, pc_o=HaltAddr.
  - dpc_we_o=1, dpc_o=dpc_q; cause_we_o=1, cause_o=cause_q; halt_o=0.
  - Next state DEBUG.
- DEBUG:
  - debug_mode_o=1, registered, first high in the cycle after ENTER.
  - debug_req_i, ebreak_i, trigger_i and step_i produce no cause/dpc writes.
  - dbg_exception_i -> same cycle flush_o=1, set_pc_o=1, pc_o=ExceptionAddr; remain in DEBUG.
  - dret_i -> same cycle flush_o=1, set_pc_o=1, pc_o=dpc_i; next state STEP if step_i else RUN; debug_mode_o=0 from the next cycle.
  - dret_i and dbg_exception_i together: the exception wins and the controller stays in DEBUG.
- Latency:
  - Sync event at cycle N -> redirect at N+1, debug_mode_o at N+2.
  - debug_req_i at N with pipeline already empty -> halt_o at N+1, ENTER at N+2.
- dpc_o/cause_o are don't-care when their write strobes are low; drive 0.

Decomposition:
- The shared debug package holds HaltAddress, ResumeAddress, ExceptionAddress and the Cause* codes.
- Add to the same package: dbg_state_e (RUN, STEP, DRAIN, ENTER, DEBUG) and CauseNone=3'h0.
- One combinational sub-module, debug_cause_prio: inputs trigger/ebreak/haltreq/step; outputs a 3-bit cause and a sync flag.

Test Plan:
- debug_req_i=1 with 3 in-flight instructions; last commit next_pc=0x8000_0010; pipe_empty_i after 4 cycles -> halt_o 1 throughout, ENTER writes dpc=0x8000_0010, cause=3, pc_o=0x800, debug_mode_o=1 next cycle.
- ebreak_i at commit_pc=0x8000_0100 with debug_req_i=1 in the same cycle -> next cycle cause=1, dpc=0x8000_0100, no drain.
- In DEBUG, dret_i with dpc_i=0x8000_0200, step_i=1; one commit with next_pc=0x8000_0204 -> re-enter with cause=4, dpc=0x8000_0204.
- In DEBUG, dbg_exception_i -> set_pc_o with pc_o=0x808, flush_o pulse, debug_mode_o stays 1, no dpc/cause write.
- trigger_i and ebreak_i on the same commit at 0x8000_0300 during DRAIN -> cause=2, dpc=0x8000_0300.
- rst_ni low during DRAIN -> all outputs 0 immediately; after release, state RUN with no CSR writes.

Source files
------------

// File: rtl/debug_entry_ctrl_pkg.sv
// Shared debug definitions: the debug module's address map, dcsr.cause codes
// and the hart-side debug controller state type.
package debug_entry_ctrl_pkg;

  localparam logic [63:0] HaltAddress      = 64'h800;
  localparam logic [63:0] ResumeAddress    = HaltAddress + 64'h4;
  localparam logic [63:0] ExceptionAddress = HaltAddress + 64'h8;

  localparam logic [2:0] CauseNone       = 3'h0;
  localparam logic [2:0] CauseBreakpoint = 3'h1;
  localparam logic [2:0] CauseTrigger    = 3'h2;
  localparam logic [2:0] CauseRequest    = 3'h3;
  localparam logic [2:0] CauseSingleStep = 3'h4;

  typedef enum logic [2:0] {
    RUN,
    STEP,
    DRAIN,
    ENTER,
    DEBUG
  } dbg_state_e;

endpackage

// File: rtl/debug_cause_prio.sv
// Debug entry cause priority encoder: trigger > ebreak > haltreq > step.
// sync_o flags events tied to a retiring instruction (no drain needed).
module debug_cause_prio
  import debug_entry_ctrl_pkg::*;
(
  input  logic       i_trigger,
  input  logic       i_ebreak,
  input  logic       i_haltreq,
  input  logic       i_step,
  output logic [2:0] o_cause,
  output logic       o_sync
);

  always_comb begin
    o_cause = CauseNone;
    if (i_trigger)      o_cause = CauseTrigger;
    else if (i_ebreak)  o_cause = CauseBreakpoint;
    else if (i_haltreq) o_cause = CauseRequest;
    else if (i_step)    o_cause = CauseSingleStep;
  end

  assign o_sync = i_trigger | i_ebreak;

endmodule

// File: rtl/debug_entry_ctrl.sv
// Hart-side debug entry/exit controller: prioritises entry causes, drains the
// pipeline, writes dpc/dcsr.cause and redirects fetch into and out of debug mode.
module debug_entry_ctrl
  import debug_entry_ctrl_pkg::*;
#(
  parameter int unsigned      XLEN          = 64,
  parameter logic [XLEN-1:0]  HaltAddr      = XLEN'(HaltAddress),
  parameter logic [XLEN-1:0]  ExceptionAddr = XLEN'(ExceptionAddress)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            debug_req_i,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            ebreak_i,
  input  logic            trigger_i,
  input  logic            step_i,
  input  logic            pipe_empty_i,
  input  logic            dret_i,
  input  logic            dbg_exception_i,
  input  logic [XLEN-1:0] dpc_i,
  output logic            halt_o,
  output logic            flush_o,
  output logic            set_pc_o,
  output logic [XLEN-1:0] pc_o,
  output logic            debug_mode_o,
  output logic            dpc_we_o,
  output logic [XLEN-1:0] dpc_o,
  output logic            cause_we_o,
  output logic [2:0]      cause_o
);

  dbg_state_e      r_state;
  dbg_state_e      w_state_next;
  logic [XLEN-1:0] r_dpc, w_dpc_next;
  logic [2:0]      r_cause, w_cause_next;
  logic [XLEN-1:0] r_last_npc;
  logic            r_debug_mode;

  logic       w_commit_trig, w_commit_ebrk, w_step_commit;
  logic [2:0] w_cause;
  logic       w_sync;

  assign w_commit_trig = commit_valid_i & trigger_i;
  assign w_commit_ebrk = commit_valid_i & ebreak_i;
  assign w_step_commit = (r_state == STEP) & commit_valid_i;

  debug_cause_prio u_prio (
    .i_trigger (w_commit_trig),
    .i_ebreak  (w_commit_ebrk),
    .i_haltreq (debug_req_i),
    .i_step    (w_step_commit),
    .o_cause   (w_cause),
    .o_sync    (w_sync)
  );

  always_comb begin
    w_state_next = r_state;
    w_dpc_next   = r_dpc;
    w_cause_next = r_cause;
    halt_o       = 1'b0;
    flush_o      = 1'b0;
    set_pc_o     = 1'b0;
    pc_o         = '0;
    dpc_we_o     = 1'b0;
    dpc_o        = '0;
    cause_we_o   = 1'b0;
    cause_o      = CauseNone;

    case (r_state)
      RUN: begin
        if (w_sync) begin
          w_dpc_next   = commit_pc_i;
          w_cause_next = w_cause;
          w_state_next = ENTER;
        end else if (debug_req_i) begin
          w_cause_next = w_cause;
          w_state_next = DRAIN;
        end
      end
      STEP: begin
        // Stop fetching as soon as the single stepped instruction retires.
        halt_o = commit_valid_i;
        if (w_sync) begin
          w_dpc_next   = commit_pc_i;
          w_cause_next = w_cause;
          w_state_next = ENTER;
        end else if (commit_valid_i || debug_req_i) begin
          w_cause_next = w_cause;
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        halt_o = 1'b1;
        if (w_sync) begin
          w_dpc_next   = commit_pc_i;
          w_cause_next = w_cause;
          w_state_next = ENTER;
        end else if (pipe_empty_i) begin
          w_dpc_next   = commit_valid_i ? next_pc_i : r_last_npc;
          w_state_next = ENTER;
        end
      end
      ENTER: begin
        flush_o      = 1'b1;
        set_pc_o     = 1'b1;
        pc_o         = HaltAddr;
        dpc_we_o     = 1'b1;
        dpc_o        = r_dpc;
        cause_we_o   = 1'b1;
        cause_o      = r_cause;
        w_state_next = DEBUG;
      end
      DEBUG: begin
        if (dbg_exception_i) begin
          flush_o  = 1'b1;
          set_pc_o = 1'b1;
          pc_o     = ExceptionAddr;
        end else if (dret_i) begin
          flush_o      = 1'b1;
          set_pc_o     = 1'b1;
          pc_o         = dpc_i;
          w_state_next = step_i ? STEP : RUN;
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= RUN;
      r_dpc        <= '0;
      r_cause      <= CauseNone;
      r_last_npc   <= '0;
      r_debug_mode <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_dpc        <= w_dpc_next;
      r_cause      <= w_cause_next;
      r_debug_mode <= (w_state_next == DEBUG);
      if (commit_valid_i && !w_sync) r_last_npc <= next_pc_i;
    end
  end

  assign debug_mode_o = r_debug_mode;

endmodule

// File: tb/tb_debug_entry_ctrl.sv
// Self-checking bench for debug_entry_ctrl: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_debug_entry_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        debug_req_i, commit_valid_i, ebreak_i, trigger_i, step_i;
  logic        pipe_empty_i, dret_i, dbg_exception_i;
  logic [63:0] commit_pc_i, next_pc_i, dpc_i;
  logic        halt_o, flush_o, set_pc_o, debug_mode_o, dpc_we_o, cause_we_o;
  logic [63:0] pc_o, dpc_o;
  logic [2:0]  cause_o;

  always #5 clk_i = ~clk_i;

  debug_entry_ctrl dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .debug_req_i     (debug_req_i),
    .commit_valid_i  (commit_valid_i),
    .commit_pc_i     (commit_pc_i),
    .next_pc_i       (next_pc_i),
    .ebreak_i        (ebreak_i),
    .trigger_i       (trigger_i),
    .step_i          (step_i),
    .pipe_empty_i    (pipe_empty_i),
    .dret_i          (dret_i),
    .dbg_exception_i (dbg_exception_i),
    .dpc_i           (dpc_i),
    .halt_o          (halt_o),
    .flush_o         (flush_o),
    .set_pc_o        (set_pc_o),
    .pc_o            (pc_o),
    .debug_mode_o    (debug_mode_o),
    .dpc_we_o        (dpc_we_o),
    .dpc_o           (dpc_o),
    .cause_we_o      (cause_we_o),
    .cause_o         (cause_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  // Stimulus for the next cycle
  bit          s_cv, s_ebk, s_trg, s_req, s_stp, s_pe, s_dret, s_exc;
  logic [63:0] s_cpc, s_npc, s_dpci;

  // Behavioural model: hart mode flags plus saved dpc/cause/last next-pc
  bit          m_dbg, m_enter, m_drain, m_step;
  logic [63:0] m_dpc, m_last;
  logic [2:0]  m_cause;

  task automatic model_reset();
    m_dbg = 0; m_enter = 0; m_drain = 0; m_step = 0;
    m_dpc = '0; m_last = '0; m_cause = '0;
  endtask

  task automatic idle();
    s_cv = 0; s_ebk = 0; s_trg = 0; s_req = 0; s_stp = 0; s_pe = 0;
    s_dret = 0; s_exc = 0; s_cpc = '0; s_npc = '0; s_dpci = '0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_halt"},  64'(halt_o), 64'd0);
    chk({pfx, "_flush"}, 64'(flush_o), 64'd0);
    chk({pfx, "_setpc"}, 64'(set_pc_o), 64'd0);
    chk({pfx, "_pc"},    pc_o, 64'd0);
    chk({pfx, "_dmode"}, 64'(debug_mode_o), 64'd0);
    chk({pfx, "_dpcwe"}, 64'(dpc_we_o), 64'd0);
    chk({pfx, "_dpc"},   dpc_o, 64'd0);
    chk({pfx, "_cwe"},   64'(cause_we_o), 64'd0);
    chk({pfx, "_cause"}, 64'(cause_o), 64'd0);
  endtask

  task automatic tick();
    bit          sync, e_halt, e_redir;
    logic [63:0] e_pc;
    logic [2:0]  sync_cause;
    @(posedge clk_i);
    #1;
    commit_valid_i = s_cv; commit_pc_i = s_cpc; next_pc_i = s_npc;
    ebreak_i = s_ebk; trigger_i = s_trg; debug_req_i = s_req; step_i = s_stp;
    pipe_empty_i = s_pe; dret_i = s_dret; dbg_exception_i = s_exc; dpc_i = s_dpci;
    #1;
    n_cyc++;
    sync       = s_cv && (s_trg || s_ebk);
    sync_cause = s_trg ? 3'd2 : 3'd1;
    e_halt     = m_drain || (m_step && s_cv);
    e_redir    = 0;
    e_pc       = '0;
    if (m_enter) begin
      e_redir = 1; e_pc = 64'h800;
    end else if (m_dbg && s_exc) begin
      e_redir = 1; e_pc = 64'h808;
    end else if (m_dbg && s_dret) begin
      e_redir = 1; e_pc = s_dpci;
    end
    $display("cyc %0d halt=%b flush=%b setpc=%b pc=%h dmode=%b dpcwe=%b dpc=%h cause=%0d",
             n_cyc, halt_o, flush_o, set_pc_o, pc_o, debug_mode_o, dpc_we_o, dpc_o, cause_o);
    chk("halt",  64'(halt_o), 64'(e_halt));
    chk("flush", 64'(flush_o), 64'(e_redir));
    chk("setpc", 64'(set_pc_o), 64'(e_redir));
    chk("pc",    pc_o, e_pc);
    chk("dmode", 64'(debug_mode_o), 64'(m_dbg));
    chk("dpcwe", 64'(dpc_we_o), 64'(m_enter));
    chk("dpc",   dpc_o, m_enter ? m_dpc : 64'd0);
    chk("cwe",   64'(cause_we_o), 64'(m_enter));
    chk("cause", 64'(cause_o), m_enter ? 64'(m_cause) : 64'd0);

    if (m_enter) begin
      m_enter = 0; m_dbg = 1;
    end else if (m_dbg) begin
      if (!s_exc && s_dret) begin
        m_dbg = 0; m_step = s_stp;
      end
    end else if (sync) begin
      m_dpc = s_cpc; m_cause = sync_cause;
      m_enter = 1; m_drain = 0; m_step = 0;
    end else if (m_drain) begin
      if (s_pe) begin
        m_dpc = s_cv ? s_npc : m_last;
        m_enter = 1; m_drain = 0;
      end
    end else if (m_step) begin
      if (s_cv || s_req) begin
        m_cause = s_req ? 3'd3 : 3'd4;
        m_drain = 1; m_step = 0;
      end
    end else if (s_req) begin
      m_cause = 3'd3; m_drain = 1;
    end
    if (s_cv && !sync) m_last = s_npc;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    model_reset();
    commit_valid_i = 0; commit_pc_i = '0; next_pc_i = '0; ebreak_i = 0;
    trigger_i = 0; debug_req_i = 0; step_i = 0; pipe_empty_i = 0;
    dret_i = 0; dbg_exception_i = 0; dpc_i = '0;
    repeat (2) @(posedge clk_i);
    #2;
    chk_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Halt request with three instructions still in flight
    idle(); s_req = 1; tick();
    chk("tp1_halt_lat", 64'(halt_o), 64'd0);
    s_cv = 1; s_npc = 64'h8000_0008; tick();
    chk("tp1_halt", 64'(halt_o), 64'd1);
    s_npc = 64'h8000_000C; tick();
    s_npc = 64'h8000_0010; tick();
    s_cv = 0; s_pe = 1; tick();
    chk("tp1_halt_end", 64'(halt_o), 64'd1);
    idle(); s_req = 1; tick();
    chk("tp1_dpc", dpc_o, 64'h8000_0010);
    chk("tp1_cause", 64'(cause_o), 64'd3);
    chk("tp1_pc", pc_o, 64'h800);
    tick();
    chk("tp1_dmode", 64'(debug_mode_o), 64'd1);

    // Exception inside debug mode
    idle(); s_exc = 1; s_dret = 1; s_dpci = 64'h1234; tick();
    chk("tp4_pc", pc_o, 64'h808);
    chk("tp4_dpcwe", 64'(dpc_we_o), 64'd0);
    idle(); tick();
    chk("tp4_dmode", 64'(debug_mode_o), 64'd1);

    // dret into single step, one commit, re-entry with step cause
    s_dret = 1; s_stp = 1; s_dpci = 64'h8000_0200; tick();
    chk("tp3_pc", pc_o, 64'h8000_0200);
    idle(); s_stp = 1; tick();
    chk("tp3_halt_pre", 64'(halt_o), 64'd0);
    chk("tp3_dmode", 64'(debug_mode_o), 64'd0);
    s_cv = 1; s_cpc = 64'h8000_0200; s_npc = 64'h8000_0204; tick();
    idle(); s_stp = 1; s_pe = 1; tick();
    idle(); tick();
    chk("tp3_dpc", dpc_o, 64'h8000_0204);
    chk("tp3_cause", 64'(cause_o), 64'd4);
    tick();
    s_dret = 1; s_dpci = 64'h8000_0204; tick();

    // ebreak with simultaneous halt request: no drain, cause breakpoint
    idle(); s_cv = 1; s_ebk = 1; s_req = 1; s_cpc = 64'h8000_0100; s_npc = 64'h8000_0104; tick();
    idle(); tick();
    chk("tp2_dpc", dpc_o, 64'h8000_0100);
    chk("tp2_cause", 64'(cause_o), 64'd1);
    tick();
    s_dret = 1; s_dpci = 64'h8000_0100; tick();

    // trigger and ebreak together during drain
    idle(); s_req = 1; tick();
    idle(); s_cv = 1; s_trg = 1; s_ebk = 1; s_cpc = 64'h8000_0300; tick();
    idle(); tick();
    chk("tp5_dpc", dpc_o, 64'h8000_0300);
    chk("tp5_cause", 64'(cause_o), 64'd2);
    tick();
    s_dret = 1; tick();

    // Reset asserted during drain
    idle(); s_req = 1; tick();
    idle(); tick();
    chk("tp6_halt_pre", 64'(halt_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1 chk_all_zero("rst_mid");
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    idle(); tick(); tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s_cv   = ($urandom_range(0, 2) == 0);
      s_cpc  = {32'h8000_0000, $urandom} & ~64'h3;
      s_npc  = s_cpc + 64'h4;
      s_ebk  = ($urandom_range(0, 9) == 0);
      s_trg  = ($urandom_range(0, 11) == 0);
      s_req  = ($urandom_range(0, 5) == 0);
      s_stp  = ($urandom_range(0, 1) == 1);
      s_pe   = ($urandom_range(0, 2) == 0);
      s_dret = ($urandom_range(0, 4) == 0);
      s_exc  = ($urandom_range(0, 7) == 0);
      s_dpci = {32'h8000_0000, $urandom};
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
